// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer: reads four ROM bytes per instruction, packs them little-endian
// and hands the word to decode over valid/ready, with redirect, halt and misalign handling.
module imem_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic              misalign_err,
    output logic [31:0]       instr_count
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [31:0] ipc_q, ipc_d;
    logic        misal_q, misal_d;
    logic [31:0] count_q, count_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            pend_q  <= 1'b0;
            lane_q  <= 2'd0;
            word_q  <= 32'd0;
            ipc_q   <= 32'd0;
            misal_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            ipc_q   <= ipc_d;
            misal_q <= misal_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        lane_d      = lane_q;
        word_d      = word_q;
        ipc_d       = ipc_q;
        misal_d     = misal_q;
        count_d     = count_q;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        instr_valid = (state_q == S_HOLD);
        halted      = (state_q == S_HALTED);
        accept      = instr_valid && instr_ready;

        // A byte returns one cycle after its read; lane_q remembers which read it was.
        if (pend_q) word_d[8*lane_q +: 8] = mem_rdata;

        case (state_q)
            S_IDLE: begin
                cnt_d   = 2'd0;
                state_d = halt_req ? S_HALTED : S_ISSUE;
            end
            S_ISSUE: begin
                mem_rd_en = 1'b1;
                mem_addr  = pc_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
                pend_d    = 1'b1;
                lane_d    = cnt_q;
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                ipc_d   = pc_q;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (accept) begin
                    pc_d    = pc_q + 32'd4;
                    count_d = count_q + 32'd1;
                    cnt_d   = 2'd0;
                    state_d = halt_req ? S_HALTED : S_ISSUE;
                end
            end
            S_HALTED: ;
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above, including a same-cycle accept.
        if (redirect_valid) begin
            pend_d  = 1'b0;
            cnt_d   = 2'd0;
            count_d = count_q;
            pc_d    = pc_q;
            if (redirect_pc[1:0] != 2'b00) begin
                misal_d = 1'b1;
                state_d = S_HALTED;
            end else begin
                pc_d    = redirect_pc;
                state_d = S_ISSUE;
            end
        end
    end

    assign instr        = word_q;
    assign instr_pc     = ipc_q;
    assign misalign_err = misal_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: ROM model, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_imem_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] instr, instr_pc, instr_count;
    logic        instr_valid, halted, misalign_err;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    imem_fetch_sequencer #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halted(halted), .misalign_err(misalign_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rb(logic [31:0] a);
        case (a)
            32'd0:   rb = 8'hB3;
            32'd1:   rb = 8'h00;
            32'd2:   rb = 8'h31;
            32'd3:   rb = 8'h00;
            default: rb = (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] rom_word(logic [31:0] pc);
        rom_word = {rb(pc + 32'd3), rb(pc + 32'd2), rb(pc + 32'd1), rb(pc)};
    endfunction

    // ROM returns the addressed byte a cycle later; junk on idle cycles.
    always @(posedge clk)
        mem_rdata <= mem_rd_en ? rb(mem_addr) : 8'($urandom);

    // Reference model: mode plus cycles elapsed since the fetch started.
    localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_HALT = 3;
    int          m_mode  = M_IDLE;
    int          m_age   = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_count = 32'h0;
    bit          m_misal = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = M_IDLE; m_pc = 32'h0; m_count = 32'h0; m_misal = 1'b0;
        end else if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                m_misal = 1'b1; m_mode = M_HALT;
            end else begin
                m_pc = redirect_pc; m_mode = M_FETCH; m_age = 0;
            end
        end else begin
            case (m_mode)
                M_IDLE: begin m_mode = halt_req ? M_HALT : M_FETCH; m_age = 0; end
                M_FETCH: begin
                    m_age++;
                    if (m_age == 5) m_mode = M_HOLD;
                end
                M_HOLD: if (instr_ready) begin
                    m_pc += 32'd4; m_count++;
                    m_mode = halt_req ? M_HALT : M_FETCH; m_age = 0;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) if (chk_en) begin
        bit rd;
        rd = (m_mode == M_FETCH) && (m_age < 4);
        chk("rd_en", 32'(mem_rd_en), 32'(rd));
        if (rd) chk("addr", mem_addr, m_pc + 32'(m_age));
        chk("valid", 32'(instr_valid), 32'(m_mode == M_HOLD));
        if (m_mode == M_HOLD) begin
            chk("instr", instr, rom_word(m_pc));
            chk("instr_pc", instr_pc, m_pc);
        end
        if (m_mode == M_IDLE) begin
            chk("idle_addr", mem_addr, 32'h0);
            chk("idle_instr", instr, 32'h0);
            chk("idle_ipc", instr_pc, 32'h0);
        end
        chk("halted", 32'(halted), 32'(m_mode == M_HALT));
        chk("misalign", 32'(misalign_err), 32'(m_misal));
        chk("count", instr_count, m_count);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_fetch(int age, string nm);
        for (int i = 0; i < 40; i++) begin
            if (m_mode == M_FETCH && m_age == age) return;
            step();
        end
        n_tot++;
        $display("FAIL %s: timeout waiting for fetch phase %0d", nm, age);
    endtask

    task automatic wait_valid(string nm);
        for (int i = 0; i < 40; i++) begin
            if (instr_valid) return;
            step();
        end
        n_tot++;
        $display("FAIL %s: timeout waiting for instr_valid", nm);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b0;
        step(); step();
        chk_en = 1'b1;
        step();
        // Reset release; cycle 0 is the idle cycle.
        reset = 1'b1;
        chk("t1_idle_rd", 32'(mem_rd_en), 32'h0);
        step();
        chk("t1_c1_rd", 32'(mem_rd_en), 32'h1);
        chk("t1_c1_addr", mem_addr, 32'h0);
        step(); step(); step();
        chk("t1_c4_addr", mem_addr, 32'h3);
        step();
        chk("t1_c5_rd", 32'(mem_rd_en), 32'h0);
        step();
        chk("t1_c6_valid", 32'(instr_valid), 32'h1);
        chk("t1_c6_instr", instr, 32'h003100B3);
        chk("t1_c6_ipc", instr_pc, 32'h0);
        // Stall in HOLD, then accept.
        for (int i = 0; i < 10; i++) step();
        chk("t2_stable", instr, 32'h003100B3);
        chk("t2_norb", 32'(mem_rd_en), 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t2_count", instr_count, 32'h1);
        chk("t2_addr", mem_addr, 32'h4);

        // Redirect during byte 2.
        instr_ready = 1'b1;
        wait_fetch(2, "t3_wait");
        redirect_valid = 1'b1; redirect_pc = 32'd16;
        step();
        redirect_valid = 1'b0;
        chk("t3_addr", mem_addr, 32'd16);
        wait_valid("t3_valid");
        chk("t3_ipc", instr_pc, 32'd16);

        // Misaligned redirect, then recovery.
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        step();
        redirect_valid = 1'b0;
        chk("t4_halted", 32'(halted), 32'h1);
        chk("t4_misal", 32'(misalign_err), 32'h1);
        step(); step();
        chk("t4_norb", 32'(mem_rd_en), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        step();
        redirect_valid = 1'b0;
        chk("t4_unhalt", 32'(halted), 32'h0);
        chk("t4_addr8", mem_addr, 32'h8);
        chk("t4_sticky", 32'(misalign_err), 32'h1);

        // Halt held off until accept; redirect beats halt.
        wait_fetch(1, "t5_wait");
        halt_req = 1'b1;
        wait_valid("t5_valid");
        chk("t5_word", instr, rom_word(32'h8));
        step();
        chk("t5_halted", 32'(halted), 32'h1);
        step(); step();
        chk("t5_norb", 32'(mem_rd_en), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'd32;
        step();
        redirect_valid = 1'b0; halt_req = 1'b0;
        chk("t5_redir_wins", 32'(halted), 32'h0);
        chk("t5_addr", mem_addr, 32'd32);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_valid("wrap_valid");
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", mem_addr, 32'h0);
        chk("wrap_rd", 32'(mem_rd_en), 32'h1);

        // Reset during DRAIN.
        wait_fetch(4, "t6_wait");
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_valid", 32'(instr_valid), 32'h0);
        chk("t6_count", instr_count, 32'h0);
        chk("t6_misal", 32'(misalign_err), 32'h0);
        chk("t6_instr", instr, 32'h0);
        step();
        chk("t6_restart", mem_addr, 32'h0);
        chk("t6_rd", 32'(mem_rd_en), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset          = ($urandom_range(0, 299) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) redirect_pc = $urandom;
            else redirect_pc = {$urandom_range(0, 63), 2'b00} | ($urandom_range(0, 9) == 0 ? 32'hFFFF_FF00 : 32'h0);
            halt_req    = ($urandom_range(0, 11) == 0);
            instr_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
